uart_loader: RTL and testbench

//  Device-side decoder for the host serial download protocol. Consumes received bytes

---
 rtl/uart_loader_if.sv | 53 +++++
 rtl/uart_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// -----------------------------------------------------------------------------
// uart_loader_if
// Bundles the byte stream coming from the uart receiver and the word-write
// bus going to core memory, plus the frame status outputs of uart_loader.
//
//   rx_re     uart receive-complete level (a new byte on its rising edge)
//   rx_data   received byte, valid while rx_re is high
//   mem_we    one-cycle memory write strobe
//   mem_addr  word address of the write
//   mem_data  write data
//   busy      loader is inside a frame
//   done      one-cycle pulse at the end of every frame
//   error     status of the last frame, valid with done
//
// Modports:
//   master  - the loader: consumes rx_*, drives memory bus and status
//   slave   - the environment: drives rx_*, observes memory bus and status
// -----------------------------------------------------------------------------
interface uart_loader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  rx_re;
   logic [7:0]            rx_data;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  busy;
   logic                  done;
   logic                  error;

   modport master (
      input  rx_re,
      input  rx_data,
      output mem_we,
      output mem_addr,
      output mem_data,
      output busy,
      output done,
      output error
   );

   modport slave (
      output rx_re,
      output rx_data,
      input  mem_we,
      input  mem_addr,
      input  mem_data,
      input  busy,
      input  done,
      input  error
   );
endinterface

// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
// Decodes the host download protocol from a stream of received uart bytes and
// turns each frame into word writes to core memory.
//
// Frame: SYNC, ADDR (ADDR_BYTES, LSB first), LEN (words-1),
//        (LEN+1)*WORD_BYTES data bytes (LSB first), SUM.
// SUM is the 8-bit wrap-around sum of every byte after SYNC up to the last
// data byte. Words are written as they complete; a bad SUM only flags the
// frame through error, it does not undo writes.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    uart_loader_if.master (rx_re/rx_data in; mem_we/mem_addr/mem_data,
//          busy, done, error out)
// -----------------------------------------------------------------------------
module uart_loader #(
   parameter int         DATA_WIDTH = 32,
   parameter int         ADDR_WIDTH = 16,
   parameter logic [7:0] SYNC_BYTE  = 8'h55,
   parameter int         TIMEOUT    = 5000000
) (
   input  logic            clk,
   input  logic            reset,
   uart_loader_if.master   bus
);

   localparam int WORD_BYTES = DATA_WIDTH / 8;
   localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
   localparam int MAX_BYTES  = (WORD_BYTES > ADDR_BYTES) ? WORD_BYTES : ADDR_BYTES;
   localparam int BCNT_W     = $clog2(MAX_BYTES + 1);
   localparam int TMR_W      = $clog2(TIMEOUT + 1);

   localparam logic [BCNT_W-1:0] ADDR_LAST = BCNT_W'(ADDR_BYTES - 1);
   localparam logic [BCNT_W-1:0] WORD_LAST = BCNT_W'(WORD_BYTES - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ADDR = 3'd1;
   localparam logic [2:0] ST_LEN  = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_SUM  = 3'd4;

   logic [2:0]              state_q,    state_d;
   logic                    rx_re_q;
   logic [BCNT_W-1:0]       byte_cnt_q, byte_cnt_d;
   logic [ADDR_BYTES*8-1:0] addr_buf_q, addr_buf_d;
   logic [ADDR_WIDTH-1:0]   base_q,     base_d;
   logic [7:0]              word_cnt_q, word_cnt_d;
   logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
   logic [DATA_WIDTH-1:0]   word_buf_q, word_buf_d;
   logic [7:0]              sum_q,      sum_d;
   logic [TMR_W-1:0]        timer_q,    timer_d;
   logic                    mem_we_q,   mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
   logic                    done_q,     done_d;
   logic                    error_q,    error_d;

   logic strobe;

   // A byte is new only on the rising edge of the receive-complete level.
   assign strobe = bus.rx_re & ~rx_re_q;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      addr_buf_d = addr_buf_q;
      base_d     = base_q;
      word_cnt_d = word_cnt_q;
      word_idx_d = word_idx_q;
      word_buf_d = word_buf_q;
      sum_d      = sum_q;
      timer_d    = timer_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      done_d     = 1'b0;
      error_d    = error_q;

      // Inter-byte watchdog: restarts on every accepted byte inside a frame.
      if (state_q != ST_IDLE) begin
         timer_d = strobe ? '0 : timer_q + TMR_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (strobe && (bus.rx_data == SYNC_BYTE)) begin
               state_d    = ST_ADDR;
               sum_d      = 8'h00;
               error_d    = 1'b0;
               byte_cnt_d = '0;
               timer_d    = '0;
            end
         end

         ST_ADDR: begin
            if (strobe) begin
               sum_d = sum_q + bus.rx_data;
               for (int i = 0; i < ADDR_BYTES; i++) begin
                  if (byte_cnt_q == BCNT_W'(i)) begin
                     addr_buf_d[i*8 +: 8] = bus.rx_data;
                  end
               end
               if (byte_cnt_q == ADDR_LAST) begin
                  // Any address bits beyond ADDR_WIDTH are dropped here.
                  base_d     = addr_buf_d[ADDR_WIDTH-1:0];
                  byte_cnt_d = '0;
                  state_d    = ST_LEN;
               end else begin
                  byte_cnt_d = byte_cnt_q + BCNT_W'(1);
               end
            end
         end

         ST_LEN: begin
            if (strobe) begin
               sum_d      = sum_q + bus.rx_data;
               word_cnt_d = bus.rx_data;
               word_idx_d = '0;
               byte_cnt_d = '0;
               state_d    = ST_DATA;
            end
         end

         ST_DATA: begin
            if (strobe) begin
               sum_d = sum_q + bus.rx_data;
               for (int i = 0; i < WORD_BYTES; i++) begin
                  if (byte_cnt_q == BCNT_W'(i)) begin
                     word_buf_d[i*8 +: 8] = bus.rx_data;
                  end
               end
               if (byte_cnt_q == WORD_LAST) begin
                  // Word complete: issue the write; address wraps naturally.
                  mem_we_d   = 1'b1;
                  mem_data_d = word_buf_d;
                  mem_addr_d = base_q + word_idx_q;
                  word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                  byte_cnt_d = '0;
                  if (word_cnt_q == 8'h00) begin
                     state_d = ST_SUM;
                  end else begin
                     word_cnt_d = word_cnt_q - 8'h01;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + BCNT_W'(1);
               end
            end
         end

         ST_SUM: begin
            if (strobe) begin
               done_d  = 1'b1;
               error_d = (bus.rx_data != sum_q);
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Watchdog expiry abandons the frame; any partial word is simply never
      // written because the byte counter restarts with the next frame.
      if ((state_q != ST_IDLE) && !strobe && (timer_q == TMR_LAST)) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         // Preset high so a level that is already high when reset releases
         // does not look like a fresh byte.
         rx_re_q    <= 1'b1;
         byte_cnt_q <= '0;
         addr_buf_q <= '0;
         base_q     <= '0;
         word_cnt_q <= '0;
         word_idx_q <= '0;
         word_buf_q <= '0;
         sum_q      <= '0;
         timer_q    <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_re_q    <= bus.rx_re;
         byte_cnt_q <= byte_cnt_d;
         addr_buf_q <= addr_buf_d;
         base_q     <= base_d;
         word_cnt_q <= word_cnt_d;
         word_idx_q <= word_idx_d;
         word_buf_q <= word_buf_d;
         sum_q      <= sum_d;
         timer_q    <= timer_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.done     = done_q;
   assign bus.error    = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_loader
// Directed frames against uart_loader (32-bit words, 16-bit addresses,
// SYNC=0x55, short watchdog). Writes and frame completions are logged at the
// falling edge and compared against hand-computed values in each test task.
// -----------------------------------------------------------------------------
module tb_uart_loader;
   localparam int TO = 100;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

   uart_loader #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(16),
      .SYNC_BYTE (8'h55),
      .TIMEOUT   (TO)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic        done_err[$];

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_data);
         $display("[%0t] write @%h = %h", $time, bus.mem_addr, bus.mem_data);
      end
      if (bus.done === 1'b1) begin
         done_err.push_back(bus.error);
         $display("[%0t] frame done, error=%b", $time, bus.error);
      end
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      done_err.delete();
   endtask

   // Called and returns at posedge+1.
   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      bus.rx_data = b;
      bus.rx_re   = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      bus.rx_re = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] f[$], input int hold, input int gap);
      foreach (f[i]) send_byte(f[i], hold, gap);
   endtask

   task automatic wait_dones(input int target, output int waited, output bit ok);
      waited = 0;
      while (done_err.size() < target && waited < 1000) begin
         @(posedge clk);
         #1;
         waited++;
      end
      ok = (done_err.size() >= target);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.mem_we, bus.done, bus.error, bus.busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got we/done/err/busy=%b expected 0000",
                  {bus.mem_we, bus.done, bus.error, bus.busy});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_data} !== 48'h0) begin
         errors++;
         $display("FAIL reset_bus: got addr=%h data=%h expected 0000/00000000",
                  bus.mem_addr, bus.mem_data);
      end
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
      end
   endtask

   task automatic test_good_frame();
      logic [7:0] f[$];
      int w;
      bit ok;
      f = '{8'h55, 8'h10, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h5D};
      clear_log();
      send_frame(f, 2, 2);
      wait_dones(1, w, ok);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL good_done_wait: no done within 1000 cycles");
      end
      checks++;
      if ({16'(wr_addr.size()), wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !==
          {16'd2, 16'h0010, 32'h12345678, 16'h0011, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL good_writes: got n=%0d %h=%h %h=%h expected 2 0010=12345678 0011=deadbeef",
                  wr_addr.size(), wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
      checks++;
      if ({8'(done_err.size()), done_err[0]} !== {8'd1, 1'b0}) begin
         errors++;
         $display("FAIL good_status: got dones=%0d err=%b expected 1 0",
                  done_err.size(), done_err[0]);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL good_busy_after: got %b expected 0", bus.busy);
      end
   endtask

   task automatic test_bad_sum();
      logic [7:0] f[$];
      int w;
      bit ok;
      f = '{8'h55, 8'h10, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h5C};
      clear_log();
      send_frame(f, 2, 2);
      wait_dones(1, w, ok);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if ({16'(wr_addr.size()), wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !==
          {16'd2, 16'h0010, 32'h12345678, 16'h0011, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL bad_writes: got n=%0d %h=%h %h=%h expected 2 0010=12345678 0011=deadbeef",
                  wr_addr.size(), wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
      checks++;
      if ({8'(done_err.size()), done_err[0]} !== {8'd1, 1'b1}) begin
         errors++;
         $display("FAIL bad_status: got dones=%0d err=%b expected 1 1",
                  done_err.size(), done_err[0]);
      end
      checks++;
      if (bus.error !== 1'b1) begin
         errors++;
         $display("FAIL bad_error_held: got %b expected 1", bus.error);
      end
      send_byte(8'h00, 2, 2);
      checks++;
      if ({bus.error, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL bad_non_sync_ignored: got err/busy=%b expected 10", {bus.error, bus.busy});
      end
      send_byte(8'h55, 2, 2);
      checks++;
      if ({bus.error, bus.busy} !== 2'b01) begin
         errors++;
         $display("FAIL bad_sync_clears: got err/busy=%b expected 01", {bus.error, bus.busy});
      end
      clear_log();
      f = '{8'h30, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h31};
      send_frame(f, 2, 2);
      wait_dones(1, w, ok);
      checks++;
      if ({16'(wr_addr.size()), wr_addr[0], wr_data[0], done_err[0]} !==
          {16'd1, 16'h0030, 32'h00000001, 1'b0}) begin
         errors++;
         $display("FAIL bad_followup: got n=%0d %h=%h err=%b expected 1 0030=00000001 0",
                  wr_addr.size(), wr_addr[0], wr_data[0], done_err[0]);
      end
   endtask

   // Fast 1-high/1-low byte cadence: the second SYNC strobes the cycle right
   // after the first frame's done pulse.
   task automatic test_wrap_back_to_back();
      logic [7:0] f[$];
      int w;
      bit ok;
      f = '{8'h00, 8'hAA, 8'h55, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h08,
            8'h55, 8'hFF, 8'hFF, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h63};
      clear_log();
      send_frame(f, 1, 1);
      wait_dones(2, w, ok);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({16'(wr_addr.size()), wr_addr[0], wr_data[0], wr_addr[1], wr_data[1],
           wr_addr[2], wr_data[2]} !==
          {16'd3, 16'hFFFF, 32'h04030201, 16'hFFFF, 32'h44332211, 16'h0000, 32'h88776655}) begin
         errors++;
         $display("FAIL wrap_writes: got n=%0d %h=%h %h=%h %h=%h expected 3 ffff=04030201 ffff=44332211 0000=88776655",
                  wr_addr.size(), wr_addr[0], wr_data[0], wr_addr[1], wr_data[1],
                  wr_addr[2], wr_data[2]);
      end
      checks++;
      if ({8'(done_err.size()), done_err[0], done_err[1]} !== {8'd2, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL b2b_status: got dones=%0d err0=%b err1=%b expected 2 0 0",
                  done_err.size(), done_err[0], done_err[1]);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] f[$];
      int w;
      bit ok;
      f = '{8'h55, 8'h10, 8'h00, 8'h00, 8'h11, 8'h22};
      clear_log();
      send_frame(f, 2, 2);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_busy_before: got %b expected 1", bus.busy);
      end
      wait_dones(1, w, ok);
      checks++;
      if (!ok || w < TO - 8 || w > TO + 2) begin
         errors++;
         $display("FAIL timeout_latency: got ok=%b after %0d cycles expected done near %0d",
                  ok, w, TO);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({16'(wr_addr.size()), 8'(done_err.size()), done_err[0], bus.busy} !==
          {16'd0, 8'd1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL timeout_status: got writes=%0d dones=%0d err=%b busy=%b expected 0 1 1 0",
                  wr_addr.size(), done_err.size(), done_err[0], bus.busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] f[$];
      int w;
      bit ok;
      f = '{8'h55, 8'h20, 8'h00, 8'h00, 8'h55, 8'hBB};
      clear_log();
      send_frame(f, 2, 2);
      checks++;
      if ({bus.busy, bus.mem_data} !== {1'b1, 32'h88776655}) begin
         errors++;
         $display("FAIL midrst_before: got busy=%b data=%h expected 1 88776655",
                  bus.busy, bus.mem_data);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.mem_we, bus.done, bus.error, bus.mem_addr, bus.mem_data} !== 52'h0) begin
         errors++;
         $display("FAIL midrst_async: got busy=%b we=%b done=%b err=%b addr=%h data=%h expected all 0",
                  bus.busy, bus.mem_we, bus.done, bus.error, bus.mem_addr, bus.mem_data);
      end
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if ({16'(wr_addr.size()), 8'(done_err.size())} !== {16'd0, 8'd0}) begin
         errors++;
         $display("FAIL midrst_quiet: got writes=%0d dones=%0d expected 0 0",
                  wr_addr.size(), done_err.size());
      end
      f = '{8'h55, 8'h40, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h4A};
      send_frame(f, 2, 2);
      wait_dones(1, w, ok);
      checks++;
      if ({16'(wr_addr.size()), wr_addr[0], wr_data[0], done_err[0]} !==
          {16'd1, 16'h0040, 32'h04030201, 1'b0}) begin
         errors++;
         $display("FAIL midrst_recover: got n=%0d %h=%h err=%b expected 1 0040=04030201 0",
                  wr_addr.size(), wr_addr[0], wr_data[0], done_err[0]);
      end
   endtask

   task automatic test_rx_high_at_reset();
      logic [7:0] f[$];
      int w;
      bit ok;
      rst_n       = 1'b0;
      bus.rx_data = 8'h55;
      bus.rx_re   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rxhigh_no_byte: got busy=%b expected 0", bus.busy);
      end
      bus.rx_re = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_log();
      f = '{8'h55, 8'h20, 8'h00, 8'h00, 8'h55, 8'hBB, 8'hCC, 8'hDD, 8'hD9};
      send_frame(f, 2, 2);
      wait_dones(1, w, ok);
      checks++;
      if ({16'(wr_addr.size()), wr_addr[0], wr_data[0], 8'(done_err.size()), done_err[0]} !==
          {16'd1, 16'h0020, 32'hDDCCBB55, 8'd1, 1'b0}) begin
         errors++;
         $display("FAIL rxhigh_frame: got n=%0d %h=%h dones=%0d err=%b expected 1 0020=ddccbb55 1 0",
                  wr_addr.size(), wr_addr[0], wr_data[0], done_err.size(), done_err[0]);
      end
   endtask

   initial begin
      bus.rx_re   = 1'b0;
      bus.rx_data = 8'h00;
      rst_n       = 1'b0;
      test_reset();
      test_good_frame();
      test_bad_sum();
      test_wrap_back_to_back();
      test_timeout();
      test_reset_mid_frame();
      test_rx_high_at_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
